// File: rtl/data_rd_responder.sv
// Data-read responder: one-cycle hits from a small direct-mapped word buffer, misses via req/ack fetch.
// Optional macro DATA_RD_BUF_EN enables the buffer; without it every read goes to the backing memory.
module data_rd_responder #(
   parameter int IDX_W = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        FLUSH,
   input  logic        INV,
   input  logic        DATA_RDEN,
   input  logic [31:0] DATA_RIADDR,
   output logic [31:0] DATA_ROADDR,
   output logic        DATA_RVALID,
   output logic [31:0] DATA_RDATA,
   output logic        DATA_STALL,
   input  logic        DATA_WREN,
   input  logic [31:0] DATA_WADDR,
   input  logic [3:0]  DATA_WSTRB,
   input  logic [31:0] DATA_WDATA,
   output logic        MEM_RD_REQ,
   output logic [31:0] MEM_RD_ADDR,
   input  logic        MEM_RD_ACK,
   input  logic [31:0] MEM_RD_DATA
);

   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [31:0] pend_data;
   logic [3:0]  pend_strb;
   logic        rd_go, rd_hit, wr_same_rd, wr_fetch;
   logic [31:0] hit_word, ack_word;
   logic        unused_bits;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++)
         if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   assign rd_go      = DATA_RDEN && !FLUSH;
   assign wr_same_rd = DATA_WREN && (DATA_WADDR[31:2] == DATA_RIADDR[31:2]);
   assign wr_fetch   = DATA_WREN && (DATA_WADDR[31:2] == MEM_RD_ADDR[31:2]);
   // Writes that raced the fetch (earlier ones in pend, this cycle's on top) override memory data
   assign ack_word   = merge_bytes(merge_bytes(MEM_RD_DATA, pend_data, pend_strb),
                                   DATA_WDATA, wr_fetch ? DATA_WSTRB : 4'b0000);
   assign DATA_STALL = (state != IDLE);

`ifdef DATA_RD_BUF_EN
   localparam int NENT  = 1 << IDX_W;
   localparam int TAG_W = 30 - IDX_W;

   logic [NENT-1:0]             buf_vld;
   logic [NENT-1:0][TAG_W-1:0]  buf_tag;
   logic [NENT-1:0][31:0]       buf_data;
   logic [IDX_W-1:0]            rd_idx, wr_idx, fill_idx;
   logic                        wr_hit, fill_en;

   assign rd_idx   = DATA_RIADDR[IDX_W+1:2];
   assign wr_idx   = DATA_WADDR[IDX_W+1:2];
   assign fill_idx = MEM_RD_ADDR[IDX_W+1:2];
   assign rd_hit   = buf_vld[rd_idx] && (buf_tag[rd_idx] == DATA_RIADDR[31:IDX_W+2]);
   assign wr_hit   = DATA_WREN && buf_vld[wr_idx] && (buf_tag[wr_idx] == DATA_WADDR[31:IDX_W+2]);
   assign hit_word = merge_bytes(buf_data[rd_idx], DATA_WDATA, wr_same_rd ? DATA_WSTRB : 4'b0000);
   assign fill_en  = (state != IDLE) && MEM_RD_ACK;
   assign unused_bits = ^{DATA_RIADDR[1:0], DATA_WADDR[1:0]};

   // Fill is ordered after INV so an in-flight fetch still lands
   always_ff @(posedge CLK) begin
      if (RST) begin
         buf_vld <= '0;
      end else begin
         if (INV)     buf_vld <= '0;
         if (fill_en) buf_vld[fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (wr_hit)
            buf_data[wr_idx] <= merge_bytes(buf_data[wr_idx], DATA_WDATA, DATA_WSTRB);
         if (fill_en) begin
            buf_tag[fill_idx]  <= MEM_RD_ADDR[31:IDX_W+2];
            buf_data[fill_idx] <= ack_word;
         end
      end
   end
`else
   assign rd_hit      = 1'b0;
   assign hit_word    = '0;
   assign unused_bits = ^{INV, DATA_RIADDR[1:0], DATA_WADDR[1:0]};
`endif

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // An ACK always completes the bus transaction; FLUSH only suppresses the return
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rd_go && !rd_hit) state_nxt = FETCH;
         FETCH:   if (MEM_RD_ACK) state_nxt = IDLE;
                  else if (FLUSH) state_nxt = DRAIN;
         DRAIN:   if (MEM_RD_ACK) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         DATA_RVALID <= 1'b0;
         DATA_RDATA  <= '0;
         DATA_ROADDR <= '0;
         MEM_RD_REQ  <= 1'b0;
         MEM_RD_ADDR <= '0;
         pend_data   <= '0;
         pend_strb   <= '0;
      end else begin
         DATA_RVALID <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_go) begin
                  if (rd_hit) begin
                     DATA_RVALID <= 1'b1;
                     DATA_RDATA  <= hit_word;
                     DATA_ROADDR <= {DATA_RIADDR[31:2], 2'b00};
                  end else begin
                     MEM_RD_REQ  <= 1'b1;
                     MEM_RD_ADDR <= {DATA_RIADDR[31:2], 2'b00};
                     pend_data   <= DATA_WDATA;
                     pend_strb   <= wr_same_rd ? DATA_WSTRB : 4'b0000;
                  end
               end
            end
            FETCH, DRAIN: begin
               if (MEM_RD_ACK) begin
                  MEM_RD_REQ <= 1'b0;
                  if (state == FETCH && !FLUSH) begin
                     DATA_RVALID <= 1'b1;
                     DATA_RDATA  <= ack_word;
                     DATA_ROADDR <= MEM_RD_ADDR;
                  end
               end else if (wr_fetch) begin
                  pend_data <= merge_bytes(pend_data, DATA_WDATA, DATA_WSTRB);
                  pend_strb <= pend_strb | DATA_WSTRB;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_rd_responder.sv
// Scoreboard bench for data_rd_responder; expected words come from a backing-memory model.
module tb_data_rd_responder;

   logic        CLK = 1'b0;
   logic        RST, FLUSH, INV, DATA_RDEN, DATA_WREN;
   logic [31:0] DATA_RIADDR, DATA_WADDR, DATA_WDATA;
   logic [3:0]  DATA_WSTRB;
   logic [31:0] DATA_ROADDR, DATA_RDATA, MEM_RD_ADDR, MEM_RD_DATA;
   logic        DATA_RVALID, DATA_STALL, MEM_RD_REQ, MEM_RD_ACK;

`ifdef DATA_RD_BUF_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } rsp_t;

   rsp_t        sb[$];
   logic [31:0] mem [logic [31:0]];
   bit   [3:0]  mvld;
   logic [27:0] mtag [4];
   int          vectors = 0, errors = 0;
   int          ack_delay = 0, wait_cnt = 0, fetch_cnt = 0;

   data_rd_responder #(.IDX_W(2)) dut (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .INV(INV),
      .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR), .DATA_ROADDR(DATA_ROADDR),
      .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA), .DATA_STALL(DATA_STALL),
      .DATA_WREN(DATA_WREN), .DATA_WADDR(DATA_WADDR), .DATA_WSTRB(DATA_WSTRB),
      .DATA_WDATA(DATA_WDATA), .MEM_RD_REQ(MEM_RD_REQ), .MEM_RD_ADDR(MEM_RD_ADDR),
      .MEM_RD_ACK(MEM_RD_ACK), .MEM_RD_DATA(MEM_RD_DATA)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      return BUF && mvld[a[3:2]] && (mtag[a[3:2]] == a[31:4]);
   endfunction

   task automatic mem_write(input logic [31:0] a, input logic [3:0] strb, input logic [31:0] d);
      logic [31:0] w;
      w = mem_word(a);
      for (int b = 0; b < 4; b++)
         if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
      mem[a] = w;
   endtask

   // Backing memory: ACK ack_delay cycles after the first REQ cycle
   initial begin
      MEM_RD_ACK  = 1'b0;
      MEM_RD_DATA = '0;
      forever begin
         @(negedge CLK);
         MEM_RD_ACK = 1'b0;
         if (MEM_RD_REQ && !RST) begin
            if (wait_cnt >= ack_delay) begin
               MEM_RD_ACK  = 1'b1;
               MEM_RD_DATA = mem_word(MEM_RD_ADDR);
               fetch_cnt++;
               mvld[MEM_RD_ADDR[3:2]] = 1'b1;
               mtag[MEM_RD_ADDR[3:2]] = MEM_RD_ADDR[31:4];
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", errors);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      RST = 1'b1; FLUSH = 1'b0; INV = 1'b0; DATA_RDEN = 1'b0; DATA_RIADDR = '0;
      DATA_WREN = 1'b0; DATA_WADDR = '0; DATA_WSTRB = '0; DATA_WDATA = '0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      mvld = '0;
      sb.delete();
   endtask

   task automatic do_write(input logic [31:0] a, input logic [3:0] strb, input logic [31:0] d);
      @(negedge CLK);
      DATA_WREN = 1'b1; DATA_WADDR = a; DATA_WSTRB = strb; DATA_WDATA = d;
      mem_write(a, strb, d);
      @(negedge CLK);
      DATA_WREN = 1'b0;
   endtask

   // One read held while stalled; optional same-cycle write to the same word
   task automatic read_chk(input logic [31:0] addr, input int dly, input bit wr,
                           input logic [3:0] wstrb, input logic [31:0] wdata,
                           input string name, output bit was_hit);
      logic [31:0] a;
      rsp_t        e, got;
      int          n, f0, exp_stall;
      a         = {addr[31:2], 2'b00};
      was_hit   = model_hit(a);
      exp_stall = was_hit ? 0 : dly + 1;
      ack_delay = dly;
      f0        = fetch_cnt;
      @(negedge CLK);
      if (wr) begin
         DATA_WREN = 1'b1; DATA_WADDR = a; DATA_WSTRB = wstrb; DATA_WDATA = wdata;
         mem_write(a, wstrb, wdata);
      end
      e.addr = a; e.data = mem_word(a);
      sb.push_back(e);
      DATA_RDEN = 1'b1; DATA_RIADDR = addr;
      @(negedge CLK);
      DATA_WREN = 1'b0;
      n = 0;
      while (DATA_STALL && n < 50) begin
         if (n == 0) begin
            vectors++;
            if (MEM_RD_ADDR !== a || MEM_RD_REQ !== 1'b1) begin
               errors++;
               $display("FAIL %s fetch: req=%b addr=%h, want req=1 addr=%h", name, MEM_RD_REQ, MEM_RD_ADDR, a);
            end
         end
         n++;
         @(negedge CLK);
      end
      DATA_RDEN = 1'b0;
      vectors++;
      if (n !== exp_stall) begin
         errors++;
         $display("FAIL %s stall cycles: got %0d want %0d", name, n, exp_stall);
      end
      vectors++;
      if ((fetch_cnt - f0) !== (was_hit ? 0 : 1)) begin
         errors++;
         $display("FAIL %s fetch count: got %0d want %0d", name, fetch_cnt - f0, was_hit ? 0 : 1);
      end
      got = sb.pop_front();
      vectors++;
      if (DATA_RVALID !== 1'b1 || DATA_RDATA !== got.data || DATA_ROADDR !== got.addr) begin
         errors++;
         $display("FAIL %s response: vld=%b data=%h addr=%h, want vld=1 data=%h addr=%h",
                  name, DATA_RVALID, DATA_RDATA, DATA_ROADDR, got.data, got.addr);
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({DATA_RVALID, DATA_STALL, MEM_RD_REQ} !== 3'b000) begin
         errors++;
         $display("FAIL reset flags: vld/stall/req=%b want 000", {DATA_RVALID, DATA_STALL, MEM_RD_REQ});
      end
      vectors++;
      if (DATA_RDATA !== 32'h0 || DATA_ROADDR !== 32'h0 || MEM_RD_ADDR !== 32'h0) begin
         errors++;
         $display("FAIL reset buses: rdata=%h roaddr=%h maddr=%h want 0", DATA_RDATA, DATA_ROADDR, MEM_RD_ADDR);
      end
      // Reset in the middle of a fetch abandons it
      ack_delay = 10;
      DATA_RDEN = 1'b1; DATA_RIADDR = 32'h400;
      @(negedge CLK);
      DATA_RDEN = 1'b0;
      vectors++;
      if (MEM_RD_REQ !== 1'b1 || DATA_STALL !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid req/stall: %b%b want 11", MEM_RD_REQ, DATA_STALL);
      end
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      vectors++;
      if (MEM_RD_REQ !== 1'b0 || DATA_STALL !== 1'b0 || DATA_RVALID !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid after: req=%b stall=%b vld=%b want 000", MEM_RD_REQ, DATA_STALL, DATA_RVALID);
      end
      do_reset();
   endtask

   task automatic test_miss();
      bit h;
      mem[32'h100] = 32'hDEADBEEF;
      read_chk(32'h100, 3, 1'b0, 4'h0, 32'h0, "miss_0x100", h);
   endtask

   task automatic test_hit();
      bit          h;
      logic [31:0] last;
      read_chk(32'h102, 0, 1'b0, 4'h0, 32'h0, "hit_0x102", h);
      last = DATA_RDATA;
      @(negedge CLK);
      vectors++;
      if (DATA_RVALID !== 1'b0 || DATA_RDATA !== last || DATA_ROADDR !== 32'h100) begin
         errors++;
         $display("FAIL idle hold: vld=%b data=%h addr=%h, want 0 %h 00000100", DATA_RVALID, DATA_RDATA, DATA_ROADDR, last);
      end
   endtask

   task automatic test_snoop();
      bit h;
      do_write(32'h100, 4'b0010, 32'h0000AA00);
      read_chk(32'h100, 0, 1'b0, 4'h0, 32'h0, "snoop_read", h);
      vectors++;
      if (DATA_RDATA !== 32'hDEADAAEF) begin
         errors++;
         $display("FAIL snoop data: got %h want deadaaef", DATA_RDATA);
      end
      read_chk(32'h100, 0, 1'b1, 4'b0100, 32'h00770000, "snoop_same_cycle", h);
      vectors++;
      if (DATA_RDATA !== 32'hDE77AAEF) begin
         errors++;
         $display("FAIL same-cycle snoop data: got %h want de77aaef", DATA_RDATA);
      end
   endtask

   task automatic test_flush();
      bit h;
      int f0;
      mem[32'h200] = 32'h12345678;
      ack_delay = 2;
      f0 = fetch_cnt;
      @(negedge CLK);
      DATA_RDEN = 1'b1; DATA_RIADDR = 32'h200;
      @(negedge CLK);
      vectors++;
      if (DATA_STALL !== 1'b1) begin
         errors++;
         $display("FAIL flush fetch start: stall=%b want 1", DATA_STALL);
      end
      FLUSH = 1'b1; DATA_RDEN = 1'b0;
      @(negedge CLK);
      FLUSH = 1'b0;
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (DATA_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL flush drain cycle %0d: rvalid=%b want 0", i, DATA_RVALID);
         end
         @(negedge CLK);
      end
      vectors++;
      if (DATA_STALL !== 1'b0 || (fetch_cnt - f0) !== 1) begin
         errors++;
         $display("FAIL flush end: stall=%b fetches=%0d want 0 1", DATA_STALL, fetch_cnt - f0);
      end
      read_chk(32'h200, 0, 1'b0, 4'h0, 32'h0, "after_flush_0x200", h);
      // FLUSH in IDLE drops the same-cycle request
      @(negedge CLK);
      DATA_RDEN = 1'b1; FLUSH = 1'b1; DATA_RIADDR = 32'h500;
      @(negedge CLK);
      DATA_RDEN = 1'b0; FLUSH = 1'b0;
      vectors++;
      if (DATA_RVALID !== 1'b0 || DATA_STALL !== 1'b0 || MEM_RD_REQ !== 1'b0) begin
         errors++;
         $display("FAIL idle flush: vld=%b stall=%b req=%b want 000", DATA_RVALID, DATA_STALL, MEM_RD_REQ);
      end
   endtask

   task automatic test_merge();
      bit   h;
      rsp_t e, got;
      int   n;
      mem[32'h30C] = 32'h11223344;
      ack_delay = 3;
      e.addr = 32'h30C; e.data = 32'hBB2233AA;
      sb.push_back(e);
      @(negedge CLK);
      DATA_RDEN = 1'b1; DATA_RIADDR = 32'h30C;
      @(negedge CLK);
      n = 0;
      while (DATA_STALL && n < 50) begin
         n++;
         DATA_WREN = (n <= 2); DATA_WADDR = 32'h30C;
         DATA_WSTRB = (n == 1) ? 4'b0001 : 4'b1000;
         DATA_WDATA = (n == 1) ? 32'h000000AA : 32'hBB000000;
         @(negedge CLK);
      end
      DATA_WREN = 1'b0; DATA_RDEN = 1'b0;
      vectors++;
      if (n !== 4) begin
         errors++;
         $display("FAIL merge stall cycles: got %0d want 4", n);
      end
      got = sb.pop_front();
      vectors++;
      if (DATA_RVALID !== 1'b1 || DATA_RDATA !== got.data || DATA_ROADDR !== got.addr) begin
         errors++;
         $display("FAIL merge response: vld=%b data=%h addr=%h want 1 %h %h",
                  DATA_RVALID, DATA_RDATA, DATA_ROADDR, got.data, got.addr);
      end
      mem[32'h30C] = 32'hBB2233AA;
      read_chk(32'h30C, 0, 1'b0, 4'h0, 32'h0, "merge_reread", h);
   endtask

   task automatic test_evict();
      bit h;
      read_chk(32'h110, 1, 1'b0, 4'h0, 32'h0, "evict_0x110", h);
      read_chk(32'h100, 0, 1'b0, 4'h0, 32'h0, "evicted_0x100", h);
   endtask

   task automatic test_inv();
      bit h;
      @(negedge CLK);
      INV = 1'b1;
      mvld = '0;
      @(negedge CLK);
      INV = 1'b0;
      read_chk(32'h100, 1, 1'b0, 4'h0, 32'h0, "after_inv_0x100", h);
   endtask

   task automatic test_back_to_back();
      bit          h;
      logic [31:0] addrs [4];
      rsp_t        e, got;
      int          i, cyc, exp_cyc;
      read_chk(32'h104, 0, 1'b0, 4'h0, 32'h0, "preload_0x104", h);
      read_chk(32'h108, 0, 1'b0, 4'h0, 32'h0, "preload_0x108", h);
      addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108; addrs[3] = 32'h100;
      ack_delay = 0;
      exp_cyc = 0;
      for (int k = 0; k < 4; k++) begin
         exp_cyc += model_hit(addrs[k]) ? 1 : 2;
         e.addr = addrs[k]; e.data = mem_word(addrs[k]);
         sb.push_back(e);
      end
      @(negedge CLK);
      DATA_RDEN = 1'b1; DATA_RIADDR = addrs[0];
      i = 1; cyc = 0;
      while (sb.size() > 0 && cyc < 60) begin
         @(negedge CLK);
         cyc++;
         if (!DATA_STALL) begin
            got = sb.pop_front();
            vectors++;
            if (DATA_RVALID !== 1'b1 || DATA_RDATA !== got.data || DATA_ROADDR !== got.addr) begin
               errors++;
               $display("FAIL b2b cycle %0d: vld=%b data=%h addr=%h want 1 %h %h",
                        cyc, DATA_RVALID, DATA_RDATA, DATA_ROADDR, got.data, got.addr);
            end
            if (i < 4) begin
               DATA_RIADDR = addrs[i];
               i++;
            end else begin
               DATA_RDEN = 1'b0;
            end
         end
      end
      DATA_RDEN = 1'b0;
      vectors++;
      if (cyc !== exp_cyc) begin
         errors++;
         $display("FAIL b2b total cycles: got %0d want %0d", cyc, exp_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_miss();
      test_hit();
      test_snoop();
      test_flush();
      test_merge();
      test_evict();
      test_inv();
      test_back_to_back();
      repeat (2) @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
